// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] result;
    logic            busy;
    logic            done;

    modport master (
        output start, flush, alu_op, srcA, srcB,
        input  result, busy, done
    );

    modport slave (
        input  start, flush, alu_op, srcA, srcB,
        output result, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M-style multiply/divide unit: single-cycle multiply, XLEN-cycle restoring divide.
//   state  | meaning
//   IDLE   | waiting for an accepted start
//   MUL    | one-cycle slot: multiply, or divide-by-zero / signed-overflow shortcut
//   DIV    | restoring divide, one quotient bit per cycle
//   DONE   | result registered, done pulse
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_result;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [CW-1:0]   r_cnt;

    logic            w_is_mul;
    logic            w_is_div;
    logic            w_div_sgn;
    logic            w_div0;
    logic            w_ovf;
    logic            w_accept;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    assign w_is_mul  = (bus.alu_op >= OP_MUL) && (bus.alu_op <= OP_MULHU);
    assign w_is_div  = (bus.alu_op >= OP_DIV) && (bus.alu_op <= OP_REMU);
    assign w_div_sgn = (bus.alu_op == OP_DIV) || (bus.alu_op == OP_REM);
    assign w_div0    = w_is_div && (bus.srcB == '0);
    assign w_ovf     = w_div_sgn && (bus.srcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.srcB == '1);
    assign w_accept  = bus.start && !bus.flush && (r_state == S_IDLE) && (w_is_mul || w_is_div);
    assign w_a_neg   = w_div_sgn && bus.srcA[XLEN-1];
    assign w_b_neg   = w_div_sgn && bus.srcB[XLEN-1];
    assign w_a_mag   = w_a_neg ? -bus.srcA : bus.srcA;
    assign w_b_mag   = w_b_neg ? -bus.srcB : bus.srcB;

    // One restoring step: bring in the next dividend bit from the top of r_quo.
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic            w_op_quo;
    logic [XLEN-1:0] w_div_res;

    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[XLEN];
    assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
    assign w_q_fin   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fin   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_op_quo  = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_div_res = w_op_quo ? w_q_fin : w_r_fin;

    // Sign-extending both operands to 2*XLEN makes one unsigned multiply serve all signedness mixes.
    logic            w_a_sx;
    logic            w_b_sx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN-1:0] w_spec_res;
    logic            w_r_is_mul;

    assign w_a_sx     = ((r_op == OP_MULH) || (r_op == OP_MULHSU)) && r_a[XLEN-1];
    assign w_b_sx     = (r_op == OP_MULH) && r_b[XLEN-1];
    assign w_prod     = {{XLEN{w_a_sx}}, r_a} * {{XLEN{w_b_sx}}, r_b};
    assign w_mul_res  = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign w_r_is_mul = (r_op >= OP_MUL) && (r_op <= OP_MULHU);

    // Divide op in the MUL slot is either divide-by-zero or signed overflow (r_a == most-negative).
    always_comb begin
        w_spec_res = '0;
        if (r_b == '0) begin
            w_spec_res = w_op_quo ? '1 : r_a;
        end else begin
            w_spec_res = w_op_quo ? r_a : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = (w_is_mul || w_div0 || w_ovf) ? S_MUL : S_DIV;
                    end
                end
                S_MUL:   w_state_nxt = S_DONE;
                S_DIV:   w_state_nxt = (r_cnt == '0) ? S_DONE : S_DIV;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy = (r_state != S_IDLE);
        bus.done = (r_state == S_DONE);
    end

    assign bus.result = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= bus.alu_op;
                r_a     <= bus.srcA;
                r_b     <= bus.srcB;
                r_quo   <= w_a_mag;
                r_rem   <= '0;
                r_dvs   <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_cnt   <= CNT_LAST;
            end else if ((r_state == S_DIV) && !bus.flush) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            if (!bus.flush) begin
                if (r_state == S_MUL) begin
                    r_result <= w_r_is_mul ? w_mul_res : w_spec_res;
                end else if ((r_state == S_DIV) && (r_cnt == '0)) begin
                    r_result <= w_div_res;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latencies, flush and reset behaviour.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    muldiv_unit_if #(.XLEN(XLEN)) bus();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in cycle 0, scramble inputs afterwards, then measure the done cycle and result.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        bus.alu_op = op;
        bus.srcA   = a;
        bus.srcB   = b;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.alu_op = 5'b00000;
        bus.srcA   = ~a;
        bus.srcB   = b + 32'd1;
        cyc = 1;
        check({tag, "_busy1"}, 32'(bus.busy), 32'd1);
        while (!bus.done && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busyD"}, 32'(bus.busy), 32'd1);
        check({tag, "_res"}, bus.result, exp_res);
        tick();
        check({tag, "_idle"}, 32'({bus.busy, bus.done}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic seen_done;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.alu_op = 5'b00000;
        bus.srcA   = '0;
        bus.srcB   = '0;

        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res", bus.result, 32'd0);
        rst_n = 1'b1;
        tick();

        // Unsupported opcode is not accepted
        bus.alu_op = 5'b00001;
        bus.srcA   = 32'd3;
        bus.srcB   = 32'd4;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        check("badop_busy", 32'(bus.busy), 32'd0);
        tick();
        check("badop_done", 32'(bus.done), 32'd0);

        run_op("mul",    OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2);
        run_op("mulhu2", OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 2);
        run_op("div",    OP_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 33);
        run_op("rem",    OP_REM,    32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 33);
        run_op("divu",   OP_DIVU,   32'd100,       32'd7,         32'd14,        33);
        run_op("remu",   OP_REMU,   32'd100,       32'd7,         32'd2,         33);
        run_op("divneg", OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("remneg", OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        run_op("divu0",  OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run_op("rem0",   OP_REM,    32'd5,         32'd0,         32'd5,         2);
        run_op("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // Flush and start together in IDLE: nothing accepted, result keeps 0 from removf
        bus.alu_op = OP_MUL;
        bus.srcA   = 32'd9;
        bus.srcB   = 32'd9;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flst_busy", 32'(bus.busy), 32'd0);
        tick();
        check("flst_done", 32'(bus.done), 32'd0);
        check("flst_res", bus.result, 32'd0);

        run_op("mul2", OP_MUL, 32'd6, 32'd7, 32'd42, 2);

        // Flush a divide in cycle 10; restarts during the divide are ignored
        bus.alu_op = OP_DIVU;
        bus.srcA   = 32'd100;
        bus.srcB   = 32'd7;
        bus.start  = 1'b1;
        tick();
        bus.alu_op = OP_MUL;
        bus.srcA   = 32'd3;
        bus.srcB   = 32'd3;
        cyc = 1;
        seen_done = 1'b0;
        while (cyc < 10) begin
            seen_done = seen_done | bus.done;
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check("fl_busy10", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        seen_done = seen_done | bus.done;
        check("fl_busy11", 32'(bus.busy), 32'd0);
        check("fl_nodone", 32'(seen_done), 32'd0);
        check("fl_res", bus.result, 32'd42);

        // Start mid-divide is ignored; divide completes unaffected
        bus.alu_op = OP_DIVU;
        bus.srcA   = 32'd100;
        bus.srcB   = 32'd7;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            if (cyc == 5) begin
                bus.start  = 1'b1;
                bus.alu_op = OP_MUL;
                bus.srcA   = 32'd3;
                bus.srcB   = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check("ign_lat", 32'(cyc), 32'd33);
        check("ign_res", bus.result, 32'd14);
        tick();
        check("ign_idle", 32'(bus.busy), 32'd0);

        // Flush while in DONE: done still shows, result already updated
        bus.alu_op = OP_MUL;
        bus.srcA   = 32'd3;
        bus.srcB   = 32'd5;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("fld_done", 32'(bus.done), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fld_busy", 32'(bus.busy), 32'd0);
        check("fld_res", bus.result, 32'd15);

        // Reset in cycle 15 of a divide
        bus.alu_op = OP_DIVU;
        bus.srcA   = 32'd100;
        bus.srcB   = 32'd7;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        check("rmid_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_busy", 32'(bus.busy), 32'd0);
        check("rmid_done", 32'(bus.done), 32'd0);
        check("rmid_res", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("mul_rst", OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
